mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the CPU's memory port: owns a word-addressed RAM, answers every CPU access (`mem_addr`/`wr_en`/`w_data` in, `r_data` out) and drives the CPU's `clk_en`, stalling it for a programmable number of wait states per access. After reset it first accepts a program image over a streaming load port while holding the CPU stalled, then switches to serving CPU accesses. It sits between the testbench/loader and `cpu` in the lab top level.

## Interface
- `ADDR_WIDTH`, default 10: log2 of RAM depth in 32-bit words (1024 words).
- `LATENCY`, default 2: wait-state cycles per CPU access, legal range 0..15.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `mem_addr`  in  32  CPU byte address.
- `wr_en`  in  1  CPU write request for the current access.
- `w_data`  in  32  CPU write data.
- `r_data`  out  32  read data returned to the CPU.
- `clk_en`  out  1  CPU step enable; high for exactly one cycle per completed access.
- `ld_valid`  in  1  load word valid.
- `ld_data`  in  32  load word.
- `ld_last`  in  1  marks the final load word.
- `ld_ready`  out  1  block accepts load words.
- `err`  out  1  sticky flag: a misaligned or out-of-range CPU access occurred.

## Operation
- States: LOAD, IDLE, WAIT, RESP. Reset state is LOAD.
- Reset values: `r_data`=0, `clk_en`=0, `ld_ready`=0 while `rst` is low, `err`=0, load pointer=0, wait counter=0. RAM contents are not reset.
- `ld_ready` = 1 exactly when state is LOAD (and `rst` is high). `clk_en` = 1 exactly when state is RESP. Both are decoded from the state register only (Moore outputs).
- **LOAD:** each cycle with `ld_valid` and `ld_ready` high writes `ld_data` to RAM[ptr] and increments ptr.
  - Go to IDLE after a beat with `ld_last` = 1.
  - Go to IDLE after the beat written at ptr = 2^ADDR_WIDTH−1, whatever `ld_last` is. The pointer never wraps.
  - CPU inputs are ignored in LOAD.
- **IDLE:** unconditionally captures `mem_addr`, `wr_en` and `w_data` into request registers on the clock edge.
  - Next state is WAIT with counter = LATENCY, or RESP directly when LATENCY = 0.
- **WAIT:** decrement the counter each cycle. Leave for RESP on the edge where the counter is 1.
- **Entering RESP** (same edge):
  - `r_data` ← RAM[word index], read-before-write: a write access returns the old contents.
  - If the captured `wr_en` is high, RAM[word index] ← captured `w_data`.
- **RESP:** lasts one cycle, then IDLE. The CPU advances on this cycle's closing edge.
- **Address decode:** word index = `mem_addr[ADDR_WIDTH+1:2]`.
  - An access is invalid if `mem_addr[1:0]` ≠ 0 or any bit of `mem_addr[31:ADDR_WIDTH+2]` is set.
  - Invalid read: `r_data` ← 0.
  - Invalid write: dropped, RAM unchanged.
  - Either case sets `err`, which stays at 1 until reset.
- `r_data` holds its value between RESP entries.
- Reset mid-operation (`rst` low at any time): immediately LOAD, `clk_en`=0, `r_data`=0. A captured but uncommitted write is discarded. Any partial load restarts at ptr 0.

## Timing
- Load throughput: 1 word/cycle.
- First IDLE cycle is the cycle after the last load beat.
- CPU access period: LATENCY+2 cycles (IDLE, LATENCY × WAIT, RESP). `clk_en` pulses once per period.
- Request sampled at the end of the IDLE cycle. `r_data` is valid throughout the RESP cycle. A write is visible to any later access.
- `rst` assertion acts asynchronously on all state and outputs. Deassertion is taken on the next `clk` rising edge.

## Test plan
- **Load then read.** Load 0x11, 0x22, 0x33 with `ld_last` on the third beat; `ld_ready` drops next cycle. CPU reads 0x8 → `r_data`=0x33 during RESP. With LATENCY=2, `clk_en` is high on exactly 1 of every 4 cycles.
- **Write then read back.** After loading 0x22 at word 1: write 0xDEADBEEF to 0x4 → `r_data`=0x00000022 in that RESP. Following read of 0x4 → 0xDEADBEEF.
- **Invalid accesses.** Read 0x6 → `r_data`=0, `err`=1. Write 0x1000 with ADDR_WIDTH=10 → RAM unchanged, `err` stays 1. Later valid read of 0x0 → 0x11, `err` still 1.
- **Reset mid-write.** Assert `rst`=0 during WAIT of a write to 0x4 → `clk_en`=0, `r_data`=0, `ld_ready`=1 after release. Reload 0x11, 0x22 with `ld_last` on the second beat; reading 0x4 returns the reloaded 0x22.
- **Full-depth load.** Stream 1024 words without `ld_last` → LOAD exits after word 1023. Reading 0xFFC returns the last word.
- **Zero latency.** With LATENCY=0, `clk_en` toggles 0,1,0,1 and a read returns data in the cycle right after the IDLE cycle.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder for the CPU memory port: streams a program image into
// a word-addressed RAM after reset, then serves CPU accesses with fixed wait states.
module mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic        wr_en,
    input  logic [31:0] w_data,
    output logic [31:0] r_data,
    output logic        clk_en,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        err
);

    localparam int                    DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0]            LAT      = 4'(LATENCY);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = '1;

    typedef enum logic [1:0] {
        S_LOAD,
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [3:0]            r_cnt;
    logic [31:0]           r_req_addr;
    logic [31:0]           r_req_wdata;
    logic                  r_req_wr;
    logic [31:0]           r_rdata;
    logic                  r_err;
    logic [31:0]           r_mem [DEPTH];

    logic [31:0]           w_acc_addr;
    logic [31:0]           w_acc_wdata;
    logic                  w_acc_wr;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_invalid;
    logic                  w_enter_resp;
    logic                  w_ld_beat;
    logic                  w_commit;

    // With zero wait states RESP is entered straight from IDLE, so the live
    // request is used on that edge instead of the not-yet-captured registers.
    always_comb begin
        w_acc_addr  = r_req_addr;
        w_acc_wdata = r_req_wdata;
        w_acc_wr    = r_req_wr;
        if (r_state == S_IDLE) begin
            w_acc_addr  = mem_addr;
            w_acc_wdata = w_data;
            w_acc_wr    = wr_en;
        end
    end

    assign w_idx        = w_acc_addr[ADDR_WIDTH+1:2];
    assign w_invalid    = (w_acc_addr[1:0] != 2'b00) ||
                          ((w_acc_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    assign w_enter_resp = ((r_state == S_IDLE) && (LAT == 4'd0)) ||
                          ((r_state == S_WAIT) && (r_cnt == 4'd1));
    assign w_ld_beat    = (r_state == S_LOAD) && ld_valid;
    assign w_commit     = w_enter_resp && w_acc_wr && !w_invalid;

    // RAM is not reset; load beats and committed CPU writes never coincide.
    always_ff @(posedge clk) begin
        if (w_ld_beat) begin
            r_mem[r_ptr] <= ld_data;
        end else if (w_commit) begin
            r_mem[w_idx] <= w_acc_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_LOAD;
            r_ptr       <= '0;
            r_cnt       <= 4'd0;
            r_req_addr  <= 32'd0;
            r_req_wdata <= 32'd0;
            r_req_wr    <= 1'b0;
            r_rdata     <= 32'd0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (ld_valid) begin
                        if (r_ptr != LAST_PTR) begin
                            r_ptr <= r_ptr + 1'b1;
                        end
                        if (ld_last || (r_ptr == LAST_PTR)) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_IDLE: begin
                    r_req_addr  <= mem_addr;
                    r_req_wdata <= w_data;
                    r_req_wr    <= wr_en;
                    if (LAT == 4'd0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt   <= LAT;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase

            // Read-before-write: the nonblocking RAM update lands after this read.
            if (w_enter_resp) begin
                if (w_invalid) begin
                    r_rdata <= 32'd0;
                    r_err   <= 1'b1;
                end else begin
                    r_rdata <= r_mem[w_idx];
                end
            end
        end
    end

    assign r_data   = r_rdata;
    assign clk_en   = (r_state == S_RESP);
    assign ld_ready = (r_state == S_LOAD) && rst;
    assign err      = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance at LATENCY=2, one at LATENCY=0.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0;

    logic [31:0] a_addr = '0, a_wdata = '0, a_rdata, a_ld_data = '0;
    logic        a_wr = 1'b0, a_clk_en, a_ld_valid = 1'b0, a_ld_last = 1'b0, a_ld_ready, a_err;
    logic [31:0] b_addr = '0, b_wdata = '0, b_rdata, b_ld_data = '0;
    logic        b_wr = 1'b0, b_clk_en, b_ld_valid = 1'b0, b_ld_last = 1'b0, b_ld_ready, b_err;

    int n_checks = 0;
    int n_errs   = 0;

    mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_dut_a (
        .clk(clk), .rst(rst),
        .mem_addr(a_addr), .wr_en(a_wr), .w_data(a_wdata),
        .r_data(a_rdata), .clk_en(a_clk_en),
        .ld_valid(a_ld_valid), .ld_data(a_ld_data), .ld_last(a_ld_last),
        .ld_ready(a_ld_ready), .err(a_err)
    );

    mem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) u_dut_b (
        .clk(clk), .rst(rst),
        .mem_addr(b_addr), .wr_en(b_wr), .w_data(b_wdata),
        .r_data(b_rdata), .clk_en(b_clk_en),
        .ld_valid(b_ld_valid), .ld_data(b_ld_data), .ld_last(b_ld_last),
        .ld_ready(b_ld_ready), .err(b_err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input bit sel, input logic [31:0] d, input logic last);
        if (!sel) begin
            a_ld_valid = 1'b1; a_ld_data = d; a_ld_last = last;
        end else begin
            b_ld_valid = 1'b1; b_ld_data = d; b_ld_last = last;
        end
        tick();
        a_ld_valid = 1'b0; a_ld_last = 1'b0;
        b_ld_valid = 1'b0; b_ld_last = 1'b0;
    endtask

    // Starts in IDLE, returns r_data seen during RESP, ends in the next IDLE.
    task automatic access(input bit sel, input string tag, input logic [31:0] addr,
                          input logic we, input logic [31:0] wd, input int lat,
                          output logic [31:0] rd);
        int n;
        bit got;
        if (!sel) begin
            a_addr = addr; a_wr = we; a_wdata = wd;
        end else begin
            b_addr = addr; b_wr = we; b_wdata = wd;
        end
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            tick();
            n++;
            if (sel ? b_clk_en : a_clk_en) got = 1'b1;
        end
        check({tag, "_lat"}, 32'(n), 32'(lat + 1));
        rd = sel ? b_rdata : a_rdata;
        tick();
        a_wr = 1'b0;
        b_wr = 1'b0;
        check({tag, "_ce_low"}, 32'(sel ? b_clk_en : a_clk_en), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int ce_cnt;

        // Reset state
        tick();
        tick();
        check("rst_rdata", a_rdata, 32'd0);
        check("rst_clk_en", 32'(a_clk_en), 32'd0);
        check("rst_ld_ready", 32'(a_ld_ready), 32'd0);
        check("rst_err", 32'(a_err), 32'd0);
        rst = 1'b1;
        #1;
        check("load_ready", 32'(a_ld_ready), 32'd1);

        // Load then read
        load_word(0, 32'h11, 1'b0);
        load_word(0, 32'h22, 1'b0);
        load_word(0, 32'h33, 1'b1);
        check("ld_ready_drop", 32'(a_ld_ready), 32'd0);
        check("idle_ce", 32'(a_clk_en), 32'd0);
        access(0, "rd8", 32'h8, 1'b0, 32'h0, 2, rd);
        check("rd8_data", rd, 32'h33);

        a_addr = 32'h0; a_wr = 1'b0;
        ce_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (a_clk_en) ce_cnt++;
        end
        check("ce_duty", 32'(ce_cnt), 32'd2);

        // Write then read back
        access(0, "wr4", 32'h4, 1'b1, 32'hDEADBEEF, 2, rd);
        check("wr4_old", rd, 32'h22);
        access(0, "rd4", 32'h4, 1'b0, 32'h0, 2, rd);
        check("rd4_new", rd, 32'hDEADBEEF);
        check("err_clean", 32'(a_err), 32'd0);

        // Invalid accesses
        access(0, "rd6", 32'h6, 1'b0, 32'h0, 2, rd);
        check("rd6_data", rd, 32'd0);
        check("rd6_err", 32'(a_err), 32'd1);
        access(0, "wr1000", 32'h1000, 1'b1, 32'h55, 2, rd);
        check("wr1000_err", 32'(a_err), 32'd1);
        access(0, "rd0", 32'h0, 1'b0, 32'h0, 2, rd);
        check("rd0_data", rd, 32'h11);
        check("rd0_err", 32'(a_err), 32'd1);

        // Reset during WAIT of a write
        a_addr = 32'h4; a_wr = 1'b1; a_wdata = 32'h99;
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_ce", 32'(a_clk_en), 32'd0);
        check("mid_rst_rdata", a_rdata, 32'd0);
        check("mid_rst_ld_ready", 32'(a_ld_ready), 32'd0);
        check("mid_rst_err", 32'(a_err), 32'd0);
        tick();
        a_wr = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_release", 32'(a_ld_ready), 32'd1);
        load_word(0, 32'h11, 1'b0);
        load_word(0, 32'h22, 1'b1);
        access(0, "reload_rd4", 32'h4, 1'b0, 32'h0, 2, rd);
        check("reload_rd4_data", rd, 32'h22);
        access(0, "reload_rd8", 32'h8, 1'b0, 32'h0, 2, rd);
        check("reload_rd8_data", rd, 32'h33);

        // Full-depth load without ld_last
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        for (int i = 0; i < 1024; i++) begin
            load_word(0, 32'hA5000000 | 32'(i), 1'b0);
            if (i == 1022) check("full_ready_1022", 32'(a_ld_ready), 32'd1);
        end
        check("full_ready_done", 32'(a_ld_ready), 32'd0);
        access(0, "full_rdffc", 32'hFFC, 1'b0, 32'h0, 2, rd);
        check("full_rdffc_data", rd, 32'hA50003FF);
        access(0, "full_rd0", 32'h0, 1'b0, 32'h0, 2, rd);
        check("full_rd0_data", rd, 32'hA5000000);
        access(0, "full_rd8", 32'h8, 1'b0, 32'h0, 2, rd);
        check("full_rd8_data", rd, 32'hA5000002);

        // Zero latency instance
        check("b_ld_ready", 32'(b_ld_ready), 32'd1);
        load_word(1, 32'h11, 1'b0);
        load_word(1, 32'h22, 1'b1);
        check("b_ld_ready_drop", 32'(b_ld_ready), 32'd0);
        check("b_ce0", 32'(b_clk_en), 32'd0);
        b_addr = 32'h4; b_wr = 1'b0;
        tick();
        check("b_ce1", 32'(b_clk_en), 32'd1);
        check("b_rd4_data", b_rdata, 32'h22);
        tick();
        check("b_ce2", 32'(b_clk_en), 32'd0);
        tick();
        check("b_ce3", 32'(b_clk_en), 32'd1);
        tick();
        check("b_ce4", 32'(b_clk_en), 32'd0);
        access(1, "b_wr0", 32'h0, 1'b1, 32'h77, 0, rd);
        check("b_wr0_old", rd, 32'h11);
        access(1, "b_rd0", 32'h0, 1'b0, 32'h0, 0, rd);
        check("b_rd0_new", rd, 32'h77);
        check("b_err", 32'(b_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
